// File: rtl/dmem_arbiter_if.sv
// Bundle of core, host and data-memory signals around the data-memory arbiter.
// slave is the arbiter's view; master is the view of the core/host/memory side.
interface dmem_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output core_rdata, core_stall, host_rdata, host_gnt,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  core_rdata, core_stall, host_rdata, host_gnt,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Core-priority data-memory arbiter with starvation-forced host bursts.
// Optional DMEM_ARB_PERF_EN adds stall / host-grant performance counters.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned MAX_BURST    = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_host_cnt
`endif
);

  typedef enum logic {CORE_PRI, HOST_BURST} state_t;

  localparam logic [7:0] WAIT_LAST  = 8'(STARVE_LIMIT - 1);
  localparam logic [7:0] WAIT_MAX   = 8'(STARVE_LIMIT);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] burst_cnt;
  logic       host_gnt;
  logic       core_srv;

  // Reset gates every grant so nothing reaches memory while reset is held.
  always_comb begin
    host_gnt = 1'b0;
    core_srv = 1'b0;
    if (!reset) begin
      if (state == HOST_BURST) host_gnt = bus.host_req;
      else                     host_gnt = bus.host_req & ~bus.core_req;
      core_srv = bus.core_req & ~host_gnt;
    end
  end

  assign bus.host_gnt   = host_gnt;
  assign bus.core_stall = bus.core_req & host_gnt;
  assign bus.mem_addr   = host_gnt ? bus.host_addr  : bus.core_addr;
  assign bus.mem_wdata  = host_gnt ? bus.host_wdata : bus.core_wdata;
  assign bus.mem_we     = (host_gnt & bus.host_we) | (core_srv & bus.core_we);
  assign bus.core_rdata = bus.mem_rdata;
  assign bus.host_rdata = bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CORE_PRI;
      wait_cnt  <= 8'd0;
      burst_cnt <= 8'd0;
    end else begin
      if (!bus.host_req || host_gnt) wait_cnt <= 8'd0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 8'd1;

      case (state)
        CORE_PRI: begin
          if (bus.host_req && !host_gnt && wait_cnt == WAIT_LAST) state <= HOST_BURST;
        end
        HOST_BURST: begin
          // host_req=1 here always means a grant this cycle.
          if (!bus.host_req || burst_cnt == BURST_LAST) begin
            state     <= CORE_PRI;
            burst_cnt <= 8'd0;
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: state <= CORE_PRI;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= 32'd0;
      perf_host_cnt  <= 32'd0;
    end else begin
      if (bus.core_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (host_gnt)       perf_host_cnt  <= perf_host_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the MIPS core's load/store path and a host port used for program loading and debug. The core normally has priority. A host that has waited too long gets a bounded burst of grants while the core is stalled. The block sits between the core's `memwrite`/`aluout`/`writedata`/`readdata` signals and the data memory. The memory has combinational read and synchronous write.

## Interface
Parameters:
- `STARVE_LIMIT`, 8: consecutive denied host cycles before a forced host burst; legal range 1..255.
- `MAX_BURST`, 4: maximum host grants per forced burst; legal range 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `core_req` in 1: core needs memory this cycle (load or store).
- `core_we` in 1: core store (driven from `memwrite`).
- `core_addr` in 32: core byte address (driven from `aluout`).
- `core_wdata` in 32: core store data (driven from `writedata`).
- `core_rdata` out 32: load data to the core.
- `core_stall` out 1: core must hold PC and suppress register/memory writes this cycle.
- `host_req` in 1: host access request; held with its command until granted.
- `host_we`, `host_addr`, `host_wdata` in 1/32/32: host command.
- `host_gnt` out 1: host access performed this cycle.
- `host_rdata` out 32: read data, valid while `host_gnt`=1.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data (combinational from `mem_addr`).

## Operation
- States: `CORE_PRI` (the reset state) and `HOST_BURST`. Counters: `wait_cnt` (8b) and `burst_cnt` (8b).
- Grant in `CORE_PRI`:
  - `host_gnt` = `host_req & ~core_req`.
  - The core is served whenever `core_req`=1.
- Grant in `HOST_BURST`:
  - `host_gnt` = `host_req`.
  - `core_stall` = `core_req & host_gnt`.
- Mux:
  - When the host is granted, `mem_*` carries the host command.
  - Otherwise `mem_*` carries the core command.
  - `mem_we` = `(host_gnt & host_we) | (core served & core_we)`; it is 0 when nobody is granted.
- Read data: `core_rdata` and `host_rdata` both equal `mem_rdata`. Only the granted side may consume it.
- `wait_cnt`:
  - Increments when `host_req & ~host_gnt`.
  - Clears when `host_gnt` or `~host_req`.
  - Saturates at `STARVE_LIMIT`.
- `CORE_PRI` → `HOST_BURST`: when `host_req & ~host_gnt & (wait_cnt == STARVE_LIMIT-1)`. The host is therefore granted on the `STARVE_LIMIT+1`-th cycle of continuous request.
- In `HOST_BURST`:
  - `burst_cnt` increments per host grant.
  - Return to `CORE_PRI` and clear `burst_cnt` after the `MAX_BURST`-th grant, or on any cycle with `host_req`=0.
  - On a cycle with `host_req`=0 the core is served in that same cycle.
- Reset mid-operation:
  - State returns to `CORE_PRI` and both counters clear.
  - While `reset`=1: `host_gnt`=0, `core_stall`=0, `mem_we`=0.
  - An in-flight host request is not granted; the host keeps holding it.

## Timing
- All outputs are combinational from the current state, counters and inputs. There are no registered outputs and no added latency.
- A write is committed at the rising edge that ends the granted cycle.
- A read is valid in the grant cycle.
- Host handshake:
  - The command must be stable while `host_req`=1.
  - Each cycle with `host_gnt`=1 completes one access.
  - The host deasserts `host_req` or presents the next command after the edge.
- Core stall: the core repeats the same `core_*` command on the next cycle. There is no stall latency beyond the current cycle.
- Forced bursts bound core stall to at most `MAX_BURST` consecutive cycles per `STARVE_LIMIT+MAX_BURST` window of continuous contention.

## Configuration
- Macro: `DMEM_ARB_PERF_EN`.
- Defined: the block adds outputs `perf_stall_cnt` (32b) and `perf_host_cnt` (32b).
  - `perf_stall_cnt` counts cycles with `core_stall`=1.
  - `perf_host_cnt` counts host grants.
  - Both clear on reset and wrap at 2^32.
- Undefined: those ports and counters are absent. Arbitration behaviour is identical.

## Test plan
- Core only: `core_req`=1 store of 0x1234_5678 to 0x40 → `mem_we`=1, `mem_addr`=0x40, `core_stall`=0, `host_gnt`=0; a subsequent load returns 0x1234_5678.
- Host only: `core_req`=0, host writes 0xDEAD_BEEF to 0x80 → `host_gnt`=1 in the same cycle; a host read of 0x80 gives `host_rdata`=0xDEAD_BEEF with `host_gnt`=1.
- Starvation, defaults: `core_req` and `host_req` held at 1 →
  - cycles 0–7: core served, no stall;
  - cycles 8–11: `host_gnt`=1 and `core_stall`=1;
  - cycle 12: core served again and `wait_cnt` restarts.
- Early burst end: host drops `host_req` after 2 burst grants → the state returns to `CORE_PRI` and the core is served in that same cycle with `core_stall`=0.
- Reset mid-burst: assert `reset` during burst grant 2 → `host_gnt`=0, `mem_we`=0 during reset; after release, `wait_cnt` has cleared to 0 and the host needs 9 more contended cycles to win.
- With `DMEM_ARB_PERF_EN`: the starvation scenario run twice → `perf_stall_cnt`=8, `perf_host_cnt`=8.
